// File: rtl/stage_strobe_decoder_pkg.sv
// Shared stage codes, strobe patterns and sequencing helpers for the stage
// strobe interface; must match the stage controller's encoding.
package stage_pkg;

    typedef enum logic [2:0] {
        ST_IF        = 3'd0,
        ST_ID        = 3'd1,
        ST_EXE       = 3'd2,
        ST_MEM       = 3'd3,
        ST_WB        = 3'd4,
        ST_RESET     = 3'd5,
        ST_DELAY_IF  = 3'd6,
        ST_DELAY_MEM = 3'd7
    } stage_e;

    // Strobe order {reset_clk, reg_clk, data_clk, pc_clk, imm_clk, done_tick}
    localparam logic [5:0] PAT_RESET     = 6'b110110;
    localparam logic [5:0] PAT_IF        = 6'b010010;
    localparam logic [5:0] PAT_DELAY_IF  = 6'b010000;
    localparam logic [5:0] PAT_ID        = 6'b000101;
    localparam logic [5:0] PAT_EXE       = 6'b000100;
    localparam logic [5:0] PAT_MEM       = 6'b001100;
    localparam logic [5:0] PAT_DELAY_MEM = 6'b000100;
    localparam logic [5:0] PAT_WB        = 6'b010110;

    function automatic stage_e succ(input stage_e s);
        case (s)
            ST_RESET:     succ = ST_IF;
            ST_IF:        succ = ST_DELAY_IF;
            ST_DELAY_IF:  succ = ST_ID;
            ST_ID:        succ = ST_EXE;
            ST_EXE:       succ = ST_MEM;
            ST_MEM:       succ = ST_DELAY_MEM;
            ST_DELAY_MEM: succ = ST_WB;
            ST_WB:        succ = ST_IF;
            default:      succ = ST_RESET;
        endcase
    endfunction

    function automatic logic [5:0] pattern(input stage_e s);
        case (s)
            ST_RESET:     pattern = PAT_RESET;
            ST_IF:        pattern = PAT_IF;
            ST_DELAY_IF:  pattern = PAT_DELAY_IF;
            ST_ID:        pattern = PAT_ID;
            ST_EXE:       pattern = PAT_EXE;
            ST_MEM:       pattern = PAT_MEM;
            ST_DELAY_MEM: pattern = PAT_DELAY_MEM;
            ST_WB:        pattern = PAT_WB;
            default:      pattern = PAT_RESET;
        endcase
    endfunction

endpackage

// File: rtl/stage_strobe_decoder_if.sv
// Strobe-in / decoded-stage-out bundle between stage controller and decoder.
interface stage_strobe_decoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       strb_i;
    logic             err_clr;
    logic             synced;
    logic [2:0]       stage_o;
    logic             fetch_en;
    logic             pc_en;
    logic             mem_en;
    logic             wb_en;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;
    logic             proto_err;
    logic             timeout_err;
    logic [2:0]       err_stage;

    modport master (
        output strb_i, err_clr,
        input  synced, stage_o, fetch_en, pc_en, mem_en, wb_en, retire,
               retire_cnt, proto_err, timeout_err, err_stage
    );

    modport slave (
        input  strb_i, err_clr,
        output synced, stage_o, fetch_en, pc_en, mem_en, wb_en, retire,
               retire_cnt, proto_err, timeout_err, err_stage
    );
endinterface

// File: rtl/stage_strobe_decoder_change_det.sv
// Registers the strobe vector, flags changes and detects a stalled vector
// while the decoder is tracking (a held RESET pattern never stalls).
module strobe_change_det
    import stage_pkg::*;
#(
    parameter int unsigned STALL_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] strb_i,
    input  logic       track_i,
    output logic       change_o,
    output logic       stall_o
);
    localparam int unsigned HW = $clog2(STALL_MAX + 1);

    logic [5:0]    vec_q;
    logic [HW-1:0] hold_q, hold_d;
    logic          frozen;

    assign change_o = (strb_i != vec_q);
    assign frozen   = (vec_q == PAT_RESET);

    always_comb begin
        hold_d = hold_q;
        if (!track_i || change_o) begin
            hold_d = '0;
        end else if (!frozen) begin
            hold_d = hold_q + HW'(1);
        end
    end

    // Fires on the edge where the unchanged-cycle count reaches STALL_MAX
    assign stall_o = track_i && !change_o && !frozen && (hold_q == HW'(STALL_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            hold_q <= '0;
        end else begin
            vec_q  <= strb_i;
            hold_q <= hold_d;
        end
    end
endmodule

// File: rtl/stage_strobe_decoder.sv
// Reconstructs the controller stage from level strobes using sequence context,
// emits stage-entry pulses, counts retirements and flags protocol faults.
module stage_strobe_decoder
    import stage_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned STALL_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stage_strobe_decoder_if.slave  bus
);
    typedef enum logic {DEC_SYNC, DEC_TRACK} dec_state_e;

    dec_state_e       state_q;
    stage_e           stage_q;
    stage_e           nxt;
    logic             fetch_q, pc_q, mem_q, wb_q, retire_q;
    logic [CNT_W-1:0] cnt_q;
    logic             proto_q, tmo_q;
    logic [2:0]       err_stage_q;
    logic             change, stall;

    strobe_change_det #(.STALL_MAX(STALL_MAX)) u_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .strb_i   (bus.strb_i),
        .track_i  (state_q == DEC_TRACK),
        .change_o (change),
        .stall_o  (stall)
    );

    assign nxt = succ(stage_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DEC_SYNC;
            stage_q     <= ST_RESET;
            fetch_q     <= 1'b0;
            pc_q        <= 1'b0;
            mem_q       <= 1'b0;
            wb_q        <= 1'b0;
            retire_q    <= 1'b0;
            cnt_q       <= '0;
            proto_q     <= 1'b0;
            tmo_q       <= 1'b0;
            err_stage_q <= '0;
        end else begin
            fetch_q  <= 1'b0;
            pc_q     <= 1'b0;
            mem_q    <= 1'b0;
            wb_q     <= 1'b0;
            retire_q <= 1'b0;
            // Later error assignments override this, so a same-cycle error wins
            if (bus.err_clr) begin
                proto_q <= 1'b0;
                tmo_q   <= 1'b0;
            end
            case (state_q)
                DEC_SYNC: begin
                    if (bus.strb_i == PAT_RESET) begin
                        stage_q <= ST_RESET;
                        state_q <= DEC_TRACK;
                    end
                end
                DEC_TRACK: begin
                    if (change) begin
                        if (bus.strb_i == pattern(nxt)) begin
                            stage_q <= nxt;
                            case (nxt)
                                ST_IF: begin
                                    fetch_q <= 1'b1;
                                    if (stage_q == ST_WB) begin
                                        retire_q <= 1'b1;
                                        cnt_q    <= cnt_q + CNT_W'(1);
                                    end
                                end
                                ST_ID:   pc_q  <= 1'b1;
                                ST_MEM:  mem_q <= 1'b1;
                                ST_WB:   wb_q  <= 1'b1;
                                default: ;
                            endcase
                        end else if (bus.strb_i == PAT_RESET) begin
                            stage_q <= ST_RESET;
                        end else begin
                            proto_q     <= 1'b1;
                            err_stage_q <= stage_q;
                            state_q     <= DEC_SYNC;
                        end
                    end else if (stall) begin
                        tmo_q       <= 1'b1;
                        err_stage_q <= stage_q;
                        state_q     <= DEC_SYNC;
                    end
                end
                default: state_q <= DEC_SYNC;
            endcase
        end
    end

    assign bus.synced      = (state_q == DEC_TRACK);
    assign bus.stage_o     = stage_q;
    assign bus.fetch_en    = fetch_q;
    assign bus.pc_en       = pc_q;
    assign bus.mem_en      = mem_q;
    assign bus.wb_en       = wb_q;
    assign bus.retire      = retire_q;
    assign bus.retire_cnt  = cnt_q;
    assign bus.proto_err   = proto_q;
    assign bus.timeout_err = tmo_q;
    assign bus.err_stage   = err_stage_q;
endmodule

// File: tb/tb_stage_strobe_decoder.sv
// Bench for stage_strobe_decoder: directed scenarios plus random strobe walks
// compared every cycle against a table-driven sequence model.
module tb_stage_strobe_decoder;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned STALL_MAX = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stage_strobe_decoder_if #(.CNT_W(CNT_W)) bus();
    stage_strobe_decoder #(.CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Pattern per stage code, and the legal walk (index 0 = RESET, loop is 1..7)
    logic [5:0] pat [8] = '{6'b010010, 6'b000101, 6'b000100, 6'b001100,
                            6'b010110, 6'b110110, 6'b010000, 6'b000100};
    int order [8] = '{5, 0, 6, 1, 2, 3, 7, 4};

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    function automatic int next_stage(input int s);
        for (int i = 0; i < 8; i++)
            if (order[i] == s) return (i == 7) ? order[1] : order[i + 1];
        return 5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    bit         m_synced, m_fetch, m_pc, m_mem, m_wb, m_retire, m_proto, m_tmo;
    int         m_stage, m_estage, m_run, m_cnt, nx;
    logic [5:0] m_prev, s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_synced = 0; m_stage = 5; m_estage = 0; m_run = 0; m_cnt = 0;
            m_prev = '0; m_proto = 0; m_tmo = 0;
            {m_fetch, m_pc, m_mem, m_wb, m_retire} = '0;
        end else begin
            s = bus.strb_i;
            {m_fetch, m_pc, m_mem, m_wb, m_retire} = '0;
            if (bus.err_clr) begin m_proto = 0; m_tmo = 0; end
            if (!m_synced) begin
                m_run = 0;
                if (s == pat[5]) begin m_synced = 1; m_stage = 5; end
            end else if (s != m_prev) begin
                m_run = 0;
                nx = next_stage(m_stage);
                if (s == pat[nx]) begin
                    m_fetch = (nx == 0);
                    m_pc    = (nx == 1);
                    m_mem   = (nx == 3);
                    m_wb    = (nx == 4);
                    if (nx == 0 && m_stage == 4) begin
                        m_retire = 1;
                        m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    end
                    m_stage = nx;
                end else if (s == pat[5]) begin
                    m_stage = 5;
                end else begin
                    m_proto = 1; m_estage = m_stage; m_synced = 0;
                end
            end else if (s != pat[5]) begin
                m_run++;
                if (m_run >= STALL_MAX) begin
                    m_tmo = 1; m_estage = m_stage; m_synced = 0; m_run = 0;
                end
            end
            m_prev = s;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("synced",      bus.synced,      m_synced);
            chk("stage_o",     bus.stage_o,     m_stage);
            chk("fetch_en",    bus.fetch_en,    m_fetch);
            chk("pc_en",       bus.pc_en,       m_pc);
            chk("mem_en",      bus.mem_en,      m_mem);
            chk("wb_en",       bus.wb_en,       m_wb);
            chk("retire",      bus.retire,      m_retire);
            chk("retire_cnt",  bus.retire_cnt,  m_cnt);
            chk("proto_err",   bus.proto_err,   m_proto);
            chk("timeout_err", bus.timeout_err, m_tmo);
            chk("err_stage",   bus.err_stage,   m_estage);
        end
    end

    // Present v (with err_clr) for one posedge; returns at the following negedge
    task automatic step(input logic [5:0] v, input logic clr);
        bus.strb_i  = v;
        bus.err_clr = clr;
        @(negedge clk);
    endtask

    task automatic walk(input int from_idx, input int to_idx);
        for (int i = from_idx; i <= to_idx; i++) step(pat[order[i]], 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_synced"},  bus.synced, 0);
        chk({tag, "_stage"},   bus.stage_o, 5);
        chk({tag, "_pulses"},  {bus.fetch_en, bus.pc_en, bus.mem_en, bus.wb_en, bus.retire}, 0);
        chk({tag, "_cnt"},     bus.retire_cnt, 0);
        chk({tag, "_errs"},    {bus.proto_err, bus.timeout_err}, 0);
        chk({tag, "_estage"},  bus.err_stage, 0);
    endtask

    initial begin
        int         r, len, pos;
        logic [5:0] v;
        bus.strb_i  = '0;
        bus.err_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Sync then three legal passes
        step(pat[5], 0);
        chk("sync_after_first_reset", bus.synced, 1);
        step(pat[5], 0); step(pat[5], 0);
        repeat (3) walk(1, 7);
        chk("three_pass_cnt", bus.retire_cnt, 2);
        chk("three_pass_stage", bus.stage_o, 4);

        // WB pattern where MEM is expected
        walk(1, 4);
        step(pat[4], 0);
        chk("illegal_proto", bus.proto_err, 1);
        chk("illegal_estage", bus.err_stage, 2);
        chk("illegal_synced", bus.synced, 0);
        step(pat[3], 0); step(pat[7], 0); step(pat[4], 0); step(pat[0], 0);
        chk("suppressed_fetch", bus.fetch_en, 0);
        step(pat[5], 0);
        chk("resync", bus.synced, 1);

        // err_clr coincident with a new error, then alone
        walk(1, 4);
        step(pat[4], 1);
        chk("clr_same_cycle", bus.proto_err, 1);
        step(pat[4], 0);
        step(pat[4], 1);
        chk("clr_alone", bus.proto_err, 0);

        // Stall in ID
        step(pat[5], 0);
        walk(1, 2);
        repeat (15) step(pat[1], 0);
        chk("stall_15", bus.timeout_err, 0);
        step(pat[1], 0);
        chk("stall_16", bus.timeout_err, 1);
        chk("stall_estage", bus.err_stage, 1);
        step(pat[5], 1);
        repeat (40) step(pat[5], 0);
        chk("reset_hold_no_tmo", bus.timeout_err, 0);
        chk("reset_hold_synced", bus.synced, 1);

        // Asynchronous reset during MEM
        walk(1, 5);
        chk("mem_pulse", bus.mem_en, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(pat[3], 0);
        chk("post_rst_synced", bus.synced, 0);
        chk("post_rst_mem_en", bus.mem_en, 0);
        step(pat[5], 0);
        chk("post_rst_resync", bus.synced, 1);

        // 17 retirements wrap a 4-bit counter
        repeat (17) walk(1, 7);
        step(pat[0], 0);
        chk("wrap_cnt", bus.retire_cnt, 1);

        // Random walk with faults, resyncs, stalls and clears
        pos = 1;
        repeat (300) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                pos = (pos == 7) ? 1 : pos + 1;
                v = pat[order[pos]];
            end else if (r < 88) begin
                pos = 0;
                v = pat[5];
            end else begin
                v = 6'($urandom);
            end
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(1, 3);
            repeat (len) step(v, ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
